fixedpoint_round_sat_stage: RTL



---
 rtl/fixedpoint_round_sat_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fixedpoint_round_sat_stage.sv
// Round/saturate a WII.WFI difference into WIR.WFR, behind a 2-entry skid buffer.
// FXP_ROUND_EN selects round-half-up; when it is undefined the stage truncates (floor).
module fixedpoint_round_sat_stage #(
  parameter int unsigned WII   = 5,
  parameter int unsigned WFI   = 4,
  parameter int unsigned WIR   = 4,
  parameter int unsigned WFR   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WII+WFI-1:0]   in_data,
  input  logic                 in_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIR+WFR-1:0]   out_data,
  output logic                 out_sat,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     sat_count
);

  localparam int unsigned IW = WII + WFI;
  localparam int unsigned RW = WIR + WFR;
  localparam int unsigned AW = WII + WFR + 1;
  localparam logic [RW-1:0] MIN_CODE = RW'(1) << (RW - 1);
  localparam logic [RW-1:0] MAX_CODE = ~MIN_CODE;

  logic signed [AW-1:0] aligned;
  logic [RW-1:0]        trunc;
  logic                 pos_clip;
  logic                 neg_clip;
  logic [RW-1:0]        conv_data_c;
  logic                 conv_sat_c;

  // Fraction alignment onto the result grid, one guard integer bit for the round carry
  generate
    if (WFR >= WFI) begin : g_pad
      localparam int unsigned LSH = WFR - WFI;
      assign aligned = AW'($signed(in_data)) <<< LSH;
    end else begin : g_round
      localparam int unsigned SH = WFI - WFR;
      logic signed [IW:0] ext;
      logic signed [IW:0] sum;
      assign ext = (IW+1)'($signed(in_data));
`ifdef FXP_ROUND_EN
      assign sum = ext + $signed((IW+1)'(1) << (SH - 1));
`else
      assign sum = ext;
`endif
      assign aligned = AW'(sum >>> SH);
    end
  endgenerate

  // Integer range check: clip when the bits above the result sign disagree with it
  generate
    if (AW > RW) begin : g_clip
      localparam int unsigned HW = AW - RW + 1;
      logic [HW-1:0] hi;
      assign hi       = aligned[AW-1:RW-1];
      assign pos_clip = ~hi[HW-1] & (|hi);
      assign neg_clip = hi[HW-1] & ~(&hi);
      assign trunc    = aligned[RW-1:0];
    end else begin : g_noclip
      assign pos_clip = 1'b0;
      assign neg_clip = 1'b0;
      assign trunc    = RW'(aligned);
    end
  endgenerate

  // Upstream overflow means the true sign is the inverse of the wrapped MSB
  always_comb begin
    conv_data_c = trunc;
    conv_sat_c  = 1'b0;
    if (in_ovf) begin
      conv_sat_c  = 1'b1;
      conv_data_c = in_data[IW-1] ? MAX_CODE : MIN_CODE;
    end else if (pos_clip) begin
      conv_sat_c  = 1'b1;
      conv_data_c = MAX_CODE;
    end else if (neg_clip) begin
      conv_sat_c  = 1'b1;
      conv_data_c = MIN_CODE;
    end
  end

  logic              main_valid_q, main_valid_d;
  logic [RW-1:0]     main_data_q,  main_data_d;
  logic              main_sat_q,   main_sat_d;
  logic              skid_valid_q, skid_valid_d;
  logic [RW-1:0]     skid_data_q,  skid_data_d;
  logic              skid_sat_q,   skid_sat_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              accept;
  logic              drain;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready;

  // Skid buffer: main refills from skid first so ordering is preserved
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_sat_d   = main_sat_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sat_d   = skid_sat_q;
    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_sat_d   = skid_sat_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = conv_data_c;
        main_sat_d   = conv_sat_c;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = conv_data_c;
      skid_sat_d   = conv_sat_c;
    end
  end

  // Saturating clip counter; clear wins over a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (accept && conv_sat_c && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sat_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sat_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sat_q   <= main_sat_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sat_q   <= skid_sat_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_sat   = main_sat_q;
  assign sat_count = cnt_q;

endmodule
